// File: rtl/dac_load_ctrl_pkg.sv
// Shared definitions for the DAC load controller: channel codes, FSM states,
// frame layout and the round-robin helper used by the arbiter.
package dac_ctrl_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [1:0] CH_HV   = 2'd0;
   localparam logic [1:0] CH_BIAS = 2'd1;
   localparam logic [1:0] CH_THR  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_LDAC
   } state_t;

   // DAC frame, sent MSB first: two zero bits, channel, data byte, four zero bits
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] ch,
                                                         input logic [7:0] data);
      return {2'b00, ch, data, 4'b0000};
   endfunction

   // Next channel in the 0 -> 1 -> 2 -> 0 rotation
   function automatic logic [1:0] rr_next(input logic [1:0] ch);
      return (ch == CH_THR) ? CH_HV : ch + 2'd1;
   endfunction

   // First pending channel searching upward from the one after the last grant
   function automatic logic [1:0] rr_pick(input logic [2:0] pend,
                                          input logic [1:0] last);
      logic [1:0] c1;
      logic [1:0] c2;
      logic [1:0] c3;
      c1 = rr_next(last);
      c2 = rr_next(c1);
      c3 = rr_next(c2);
      if (pend[c1])
         return c1;
      else if (pend[c2])
         return c2;
      else
         return c3;
   endfunction

endpackage

// File: rtl/dac_load_ctrl_if.sv
// Bundle of the NI-side write strobes and the DAC pin/status outputs.
// The controller uses the slave view; whatever drives the strobes uses master.
interface dac_load_ctrl_if;

   logic [7:0] din;
   logic       set_hvdac;
   logic       set_biasdac;
   logic       set_thrshdac;
   logic       dac_sclk;
   logic       dac_sync_n;
   logic       dac_sdi;
   logic       dac_ldac_n;
   logic       busy;
   logic       done;
   logic [1:0] cur_chan;

   modport master (
      output din, set_hvdac, set_biasdac, set_thrshdac,
      input  dac_sclk, dac_sync_n, dac_sdi, dac_ldac_n, busy, done, cur_chan
   );

   modport slave (
      input  din, set_hvdac, set_biasdac, set_thrshdac,
      output dac_sclk, dac_sync_n, dac_sdi, dac_ldac_n, busy, done, cur_chan
   );

endinterface

// File: rtl/dac_load_ctrl_spi_shift.sv
// SPI bit engine: tick divider, frame shift register and sclk/sdi generation.
// The parent loads a frame while idle, then holds 'active' high for the whole
// transfer and 'shifting' high while the clock burst should run.
module dac_spi_shift
   import dac_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] frame,
   input  logic                  active,
   input  logic                  shifting,
   output logic                  tick,
   output logic                  frame_end,
   output logic                  sclk,
   output logic                  sdi
);

   localparam logic [7:0] TICK_MAX  = 8'(CLK_DIV - 1);
   localparam logic [4:0] EDGE_LAST = 5'(2 * FRAME_BITS - 1);

   logic [7:0]            div_cnt;
   logic [4:0]            edge_cnt;
   logic [FRAME_BITS-1:0] shreg;

   assign tick      = active && (div_cnt == TICK_MAX);
   assign frame_end = shifting && tick && (edge_cnt == EDGE_LAST);

   // Half-period divider: restarts on every frame load, frozen while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= 8'd0;
      end else if (load) begin
         div_cnt <= 8'd0;
      end else if (active) begin
         if (tick)
            div_cnt <= 8'd0;
         else
            div_cnt <= div_cnt + 8'd1;
      end
   end

   // sclk toggles each tick while shifting; sdi advances on each falling edge
   // so it is stable across the following rising edge where the DAC samples
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         edge_cnt <= 5'd0;
         sclk     <= 1'b0;
         sdi      <= 1'b0;
      end else if (load) begin
         shreg    <= frame;
         edge_cnt <= 5'd0;
         sclk     <= 1'b0;
         sdi      <= frame[FRAME_BITS-1];
      end else if (shifting && tick) begin
         edge_cnt <= edge_cnt + 5'd1;
         sclk     <= ~sclk;
         if (sclk) begin
            if (edge_cnt == EDGE_LAST) begin
               sdi <= 1'b0;
            end else begin
               shreg <= {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
               sdi   <= shreg[FRAME_BITS-2];
            end
         end
      end
   end

endmodule

// File: rtl/dac_load_ctrl.sv
// Shares the single serial DAC between the HV, bias and threshold write
// commands. Writes land in shadow registers and mark their channel pending;
// a round-robin arbiter picks one pending channel per frame, the frame is
// shifted out and LDAC is pulsed before the next grant.
module dac_load_ctrl
   import dac_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic           clk,
   input  logic           rst,
   dac_load_ctrl_if.slave bus
);

   state_t                state;
   logic [7:0]            shadow [3];
   logic [2:0]            pending;
   logic [2:0]            strobe;
   logic [1:0]            rr;
   logic [1:0]            grant;
   logic                  grant_valid;
   logic [FRAME_BITS-1:0] frame;
   logic                  tick;
   logic                  frame_end;
   logic                  sclk;
   logic                  sdi;
   logic                  sync_n;
   logic                  ldac_n;
   logic                  busy;
   logic                  done;
   logic [1:0]            cur_chan;

   assign strobe[CH_HV]   = bus.set_hvdac;
   assign strobe[CH_BIAS] = bus.set_biasdac;
   assign strobe[CH_THR]  = bus.set_thrshdac;

   assign grant       = rr_pick(pending, rr);
   assign grant_valid = (state == ST_IDLE) && (pending != 3'b000);
   assign frame       = build_frame(grant, shadow[grant]);

   dac_spi_shift #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (grant_valid),
      .frame     (frame),
      .active    (state != ST_IDLE),
      .shifting  (state == ST_SHIFT),
      .tick      (tick),
      .frame_end (frame_end),
      .sclk      (sclk),
      .sdi       (sdi)
   );

   // Shadow registers follow the write strobes regardless of transfer state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int ch = 0; ch < 3; ch++)
            shadow[ch] <= 8'h00;
      end else begin
         for (int ch = 0; ch < 3; ch++)
            if (strobe[ch])
               shadow[ch] <= bus.din;
      end
   end

   // Arbiter and transfer sequencer; a strobe landing on the granted channel
   // is applied after the grant clear so that channel stays pending
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pending  <= 3'b000;
         rr       <= CH_THR;
         cur_chan <= CH_HV;
         sync_n   <= 1'b1;
         ldac_n   <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  pending[grant] <= 1'b0;
                  rr             <= grant;
                  cur_chan       <= grant;
                  sync_n         <= 1'b0;
                  busy           <= 1'b1;
                  state          <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick)
                  state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (frame_end) begin
                  sync_n <= 1'b1;
                  state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  ldac_n <= 1'b0;
                  state  <= ST_LDAC;
               end
            end
            ST_LDAC: begin
               if (tick) begin
                  ldac_n <= 1'b1;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
         for (int ch = 0; ch < 3; ch++)
            if (strobe[ch])
               pending[ch] <= 1'b1;
      end
   end

   assign bus.dac_sclk   = sclk;
   assign bus.dac_sync_n = sync_n;
   assign bus.dac_sdi    = sdi;
   assign bus.dac_ldac_n = ldac_n;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.cur_chan   = cur_chan;

endmodule

// File: tb/tb_dac_load_ctrl.sv
// Self-checking bench for dac_load_ctrl. A transaction-level model tracks
// shadow data, pending flags and when the controller is free again, and
// predicts each frame word, channel and done cycle. A monitor reassembles
// frames from the DAC pins and compares them against those predictions.
module tb_dac_load_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int FRAME_CYC = 35 * CLK_DIV;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dac_load_ctrl_if bus ();

   dac_load_ctrl #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_bad    = 0;
   int cyc      = 0;

   // reference model state
   logic [7:0] m_shadow [3];
   logic [2:0] m_pending;
   int         m_last;
   int         m_free_at;
   int         exp_frame_q [$];
   int         exp_chan_q  [$];
   int         exp_done_q  [$];

   // monitor state
   logic        prev_sclk = 1'b0;
   logic        prev_sync = 1'b1;
   logic        prev_ldac = 1'b1;
   logic [15:0] cap       = 16'h0000;
   int          cap_bits  = 0;
   int          ldac_len  = 0;
   int          frames_seen = 0;
   int          dones_seen  = 0;
   logic [15:0] last_frame  = 16'h0000;

   task automatic checkOutput(input string tag, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic monitorCycle();
      logic exp_d;
      exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
      if (exp_d || bus.done === 1'b1)
         checkOutput("done", 32'(bus.done), 32'(exp_d));
      if (exp_d)
         void'(exp_done_q.pop_front());
      if (bus.done === 1'b1)
         dones_seen++;
      if (!bus.dac_sync_n && prev_sync)
         checkOutput("busy_at_frame_start", 32'(bus.busy), 32'd1);
      if (!bus.dac_sync_n && bus.dac_sclk && !prev_sclk) begin
         cap = {cap[14:0], bus.dac_sdi};
         cap_bits++;
      end
      if (bus.dac_sync_n && !prev_sync) begin
         checkOutput("frame_bits", cap_bits, 16);
         if (exp_frame_q.size() > 0) begin
            checkOutput("frame", 32'(cap), exp_frame_q.pop_front());
            checkOutput("cur_chan", 32'(bus.cur_chan), exp_chan_q.pop_front());
         end else begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
         end
         last_frame = cap;
         frames_seen++;
         cap_bits = 0;
      end
      if (!bus.dac_ldac_n) begin
         ldac_len++;
      end else if (!prev_ldac) begin
         checkOutput("ldac_len", ldac_len, CLK_DIV);
         ldac_len = 0;
      end
      prev_sclk = bus.dac_sclk;
      prev_sync = bus.dac_sync_n;
      prev_ldac = bus.dac_ldac_n;
   endtask

   // One clock: sample this cycle's outputs, then drive inputs that the
   // DUT samples at the end of the cycle and advance the model alongside.
   task automatic applyStimulus(input logic r, input logic [7:0] d,
                                input logic [2:0] s);
      int g;
      @(negedge clk);
      cyc++;
      monitorCycle();
      rst              = r;
      bus.din          = d;
      bus.set_hvdac    = s[0];
      bus.set_biasdac  = s[1];
      bus.set_thrshdac = s[2];
      if (r) begin
         for (int ch = 0; ch < 3; ch++) m_shadow[ch] = 8'h00;
         m_pending = 3'b000;
         m_last    = 2;
         m_free_at = cyc + 1;
         exp_frame_q.delete();
         exp_chan_q.delete();
         exp_done_q.delete();
         prev_sync = 1'b1;
         prev_ldac = 1'b1;
         cap_bits  = 0;
         ldac_len  = 0;
      end else begin
         if (cyc >= m_free_at && m_pending != 3'b000) begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
               int ch;
               ch = (m_last + k) % 3;
               if (m_pending[ch] && g < 0) g = ch;
            end
            exp_frame_q.push_back((g << 12) | (int'(m_shadow[g]) << 4));
            exp_chan_q.push_back(g);
            exp_done_q.push_back(cyc + 1 + FRAME_CYC);
            m_pending[g] = 1'b0;
            m_last       = g;
            m_free_at    = cyc + 1 + FRAME_CYC;
         end
         for (int ch = 0; ch < 3; ch++)
            if (s[ch]) begin
               m_shadow[ch]  = d;
               m_pending[ch] = 1'b1;
            end
      end
   endtask

   task automatic checkResetState();
      @(posedge clk);
      #1;
      checkOutput("rst_sclk",     32'(bus.dac_sclk),   32'd0);
      checkOutput("rst_sync_n",   32'(bus.dac_sync_n), 32'd1);
      checkOutput("rst_sdi",      32'(bus.dac_sdi),    32'd0);
      checkOutput("rst_ldac_n",   32'(bus.dac_ldac_n), 32'd1);
      checkOutput("rst_busy",     32'(bus.busy),       32'd0);
      checkOutput("rst_done",     32'(bus.done),       32'd0);
      checkOutput("rst_cur_chan", 32'(bus.cur_chan),   32'd0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 8'h00, 3'b000);
      checkResetState();
      applyStimulus(1'b0, 8'h00, 3'b000);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 8'($urandom), 3'b000);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((exp_frame_q.size() != 0 || exp_done_q.size() != 0 ||
              cyc < m_free_at || m_pending != 3'b000) && n < 3000) begin
         applyStimulus(1'b0, 8'h00, 3'b000);
         n++;
      end
      if (n >= 3000)
         checkOutput("wait_idle_timeout", 32'd1, 32'd0);
      idleCycles(2);
   endtask

   initial begin
      int base_f;
      int base_d;
      int n;
      rst              = 1'b1;
      bus.din          = 8'h00;
      bus.set_hvdac    = 1'b0;
      bus.set_biasdac  = 1'b0;
      bus.set_thrshdac = 1'b0;
      doReset();

      // single bias write
      base_f = frames_seen;
      applyStimulus(1'b0, 8'hA5, 3'b010);
      waitIdle();
      checkOutput("t1_frames", frames_seen - base_f, 1);
      checkOutput("t1_frame", 32'(last_frame), 32'h1A50);

      // all three strobes together
      doReset();
      base_f = frames_seen;
      base_d = dones_seen;
      applyStimulus(1'b0, 8'h3C, 3'b111);
      waitIdle();
      checkOutput("t2_frames", frames_seen - base_f, 3);
      checkOutput("t2_dones", dones_seen - base_d, 3);
      checkOutput("t2_last", 32'(last_frame), 32'h23C0);

      // round robin: ch2 must beat ch0 after a ch0 frame
      doReset();
      base_f = frames_seen;
      applyStimulus(1'b0, 8'h10, 3'b001);
      idleCycles(20);
      applyStimulus(1'b0, 8'h20, 3'b001);
      applyStimulus(1'b0, 8'h30, 3'b100);
      waitIdle();
      checkOutput("t3_frames", frames_seen - base_f, 3);
      checkOutput("t3_last", 32'(last_frame), 32'h0200);

      // overwrite of a pending channel
      doReset();
      base_f = frames_seen;
      applyStimulus(1'b0, 8'h01, 3'b001);
      idleCycles(10);
      applyStimulus(1'b0, 8'h11, 3'b100);
      idleCycles(10);
      applyStimulus(1'b0, 8'h22, 3'b100);
      waitIdle();
      checkOutput("t4_frames", frames_seen - base_f, 2);
      checkOutput("t4_last", 32'(last_frame), 32'h2220);

      // strobe on the granted channel during its grant cycle
      doReset();
      base_f = frames_seen;
      applyStimulus(1'b0, 8'h44, 3'b001);
      applyStimulus(1'b0, 8'h55, 3'b001);
      waitIdle();
      checkOutput("t5_frames", frames_seen - base_f, 2);
      checkOutput("t5_last", 32'(last_frame), 32'h0550);

      // reset in the middle of the shift phase
      doReset();
      base_f = frames_seen;
      base_d = dones_seen;
      applyStimulus(1'b0, 8'h77, 3'b010);
      applyStimulus(1'b0, 8'h66, 3'b100);
      n = 0;
      while (cap_bits != 7 && n < 400) begin
         applyStimulus(1'b0, 8'h00, 3'b000);
         n++;
      end
      if (n >= 400)
         checkOutput("t6_bit7_timeout", 32'd1, 32'd0);
      applyStimulus(1'b1, 8'h00, 3'b000);
      checkResetState();
      idleCycles(FRAME_CYC + 20);
      checkOutput("t6_frames", frames_seen - base_f, 0);
      checkOutput("t6_dones", dones_seen - base_d, 0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic [2:0] s;
         logic       r;
         s[0] = ($urandom_range(0, 24) == 0);
         s[1] = ($urandom_range(0, 24) == 0);
         s[2] = ($urandom_range(0, 24) == 0);
         r    = ($urandom_range(0, 599) == 0);
         applyStimulus(r, 8'($urandom), s);
      end
      waitIdle();
      checkOutput("final_frames_left", exp_frame_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
